dma_tcq_arb: RTL and testbench
==============================

// Module: dma_tcq_arb
// PURPOSE
// - Shares one PCIe memory-write transfer command queue (TCQ) between two DMA request engines (port 0 = RX DMA, port 1 = auxiliary/second DMA).
// - Round-robin arbitration with a per-port outstanding-request credit limit.
// - Upstream tag = {port, local tag}; completions route back to the owning port by tag MSB.
// - Sits between the DMA request engines and the PCIe write-request generator.
// PARAMETERS
// - BUFFER_SIZE_BITS  16  local FIFO address width (bytes)
// - BUFFER_BURST_BITS 6   request length field base width
// - REMOTE_ADDR_WIDTH 32  host address width (bytes)
// - DATA_BITS         4   log2 bytes per word; fields below it are dropped
// - MEM_TAG           5   per-port tag width; upstream tag is MEM_TAG+1
// - MAX_OUTSTANDING   4   max un-completed requests per port (1..15)
// PORTS (N = 0,1)
// - clk                input  1   clock
// - rst                input  1   asynchronous active-high reset
// - sN_tcq_valid/ready in/out 1   request handshake, port N
// - sN_tcq_laddr       input  BUFFER_SIZE_BITS-DATA_BITS        local address
// - sN_tcq_raddr       input  REMOTE_ADDR_WIDTH-DATA_BITS       host address
// - sN_tcq_length      input  BUFFER_BURST_BITS+3-DATA_BITS     length-1, in words
// - sN_tcq_tag         input  MEM_TAG   local tag
// - sN_tcq_cvalid/cready out/in 1 completion handshake, port N
// - sN_tcq_ctag        output MEM_TAG   completed local tag
// - m_tcq_valid/ready  out/in 1   merged request handshake
// - m_tcq_laddr/raddr/length  output  as sN_*  registered payload
// - m_tcq_tag          output MEM_TAG+1 {port, local tag}
// - m_tcq_cvalid/cready in/out 1  merged completion handshake
// - m_tcq_ctag         input  MEM_TAG+1 completed upstream tag
// - port_en            input  2   per-port enable; 0 = port not eligible
// - arb_err            output 1   sticky: completion for port with zero outstanding
// BEHAVIOUR
// - Reset: state IDLE, all sN_tcq_ready=0, m_tcq_valid=0, rr pointer=0, outstanding counters=0, arb_err=0; m_tcq payload undefined.
// - Eligible(N) = sN_tcq_valid & port_en[N] & (outst[N] < MAX_OUTSTANDING).
// - IDLE: if any port eligible, grant: both eligible -> port = rr pointer; else the single eligible port.
//   On grant: latch payload and {N,tag} into m_tcq_*, pulse sN_tcq_ready=1 for exactly that cycle, set m_tcq_valid=1, go ISSUE.
// - ISSUE: hold m_tcq_* stable; on m_tcq_valid & m_tcq_ready: m_tcq_valid<=0, outst[granted]+1, rr pointer <= ~granted, go IDLE.
// - Throughput: at most one request per 2 cycles; grant-to-m_tcq_valid latency 1 cycle.
// - Deasserting port_en during ISSUE does not cancel the latched request.
// - Completions are combinational: port P = m_tcq_ctag[MEM_TAG]; sP_tcq_cvalid = m_tcq_cvalid; sP_tcq_ctag = m_tcq_ctag[MEM_TAG-1:0]; m_tcq_cready = sP_tcq_cready; other port cvalid=0.
// - Completion handshake on port P: outst[P]-1. Same-cycle issue and completion on the same port: counter unchanged.
// - Completion with outst[P]==0: counter stays 0 (no wrap), arb_err<=1 until reset.
// - Counters are width clog2(MAX_OUTSTANDING+1); they never exceed MAX_OUTSTANDING.
// - Async reset mid-ISSUE drops the pending request; the issuing engine restarts on its own reset.
// CONFIGURATION
// - DMA_TCQ_ARB_STATS_EN defined: adds output arb_stat[31:0] = {grant_cnt1[15:0], grant_cnt0[15:0]};
//   each count increments on m_tcq handshake for its port, wraps at 16 bits, clears on reset.
// - Undefined: no arb_stat port, no counter logic.
// TESTING
// - Port 0 only, 3 requests tag 1,2,3, m_tcq_ready=1 -> m_tcq_tag 0x01,0x02,0x03, one issue every 2 cycles.
// - Both ports valid continuously after reset -> grant order 0,1,0,1; m_tcq_tag MSB alternates.
// - MAX_OUTSTANDING=4, port 0 valid, no completions -> exactly 4 issues, then s0_tcq_ready stays 0; one completion tag 0x02 -> 5th issue.
// - m_tcq_ctag=0x25, s1_tcq_cready=0 for 3 cycles -> s1_tcq_cvalid=1, s1_tcq_ctag=5, m_tcq_cready=0 until cready.
// - Completion tag 0x01 with outst[0]=0 -> arb_err=1, outst[0] stays 0; async rst -> arb_err=0.
// - Async rst asserted during ISSUE -> m_tcq_valid=0 same cycle, state IDLE, counters 0.

Source files
------------

// File: rtl/dma_tcq_arb.sv
// dma_tcq_arb: round-robin sharing of one PCIe write TCQ between two DMA engines with per-port credit limits.
// Define DMA_TCQ_ARB_STATS_EN to add the arb_stat per-port grant counters.
module dma_tcq_arb #(
    parameter int BUFFER_SIZE_BITS  = 16,
    parameter int BUFFER_BURST_BITS = 6,
    parameter int REMOTE_ADDR_WIDTH = 32,
    parameter int DATA_BITS         = 4,
    parameter int MEM_TAG           = 5,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s0_tcq_valid,
    output logic                                   s0_tcq_ready,
    input  logic [BUFFER_SIZE_BITS-DATA_BITS-1:0]  s0_tcq_laddr,
    input  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0] s0_tcq_raddr,
    input  logic [BUFFER_BURST_BITS+3-DATA_BITS-1:0] s0_tcq_length,
    input  logic [MEM_TAG-1:0]                     s0_tcq_tag,
    output logic                                   s0_tcq_cvalid,
    input  logic                                   s0_tcq_cready,
    output logic [MEM_TAG-1:0]                     s0_tcq_ctag,
    input  logic                                   s1_tcq_valid,
    output logic                                   s1_tcq_ready,
    input  logic [BUFFER_SIZE_BITS-DATA_BITS-1:0]  s1_tcq_laddr,
    input  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0] s1_tcq_raddr,
    input  logic [BUFFER_BURST_BITS+3-DATA_BITS-1:0] s1_tcq_length,
    input  logic [MEM_TAG-1:0]                     s1_tcq_tag,
    output logic                                   s1_tcq_cvalid,
    input  logic                                   s1_tcq_cready,
    output logic [MEM_TAG-1:0]                     s1_tcq_ctag,
    output logic                                   m_tcq_valid,
    input  logic                                   m_tcq_ready,
    output logic [BUFFER_SIZE_BITS-DATA_BITS-1:0]  m_tcq_laddr,
    output logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0] m_tcq_raddr,
    output logic [BUFFER_BURST_BITS+3-DATA_BITS-1:0] m_tcq_length,
    output logic [MEM_TAG:0]                       m_tcq_tag,
    input  logic                                   m_tcq_cvalid,
    output logic                                   m_tcq_cready,
    input  logic [MEM_TAG:0]                       m_tcq_ctag,
    input  logic [1:0]                             port_en,
`ifdef DMA_TCQ_ARB_STATS_EN
    output logic [31:0]                            arb_stat,
`endif
    output logic                                   arb_err
);
    localparam int LW = BUFFER_SIZE_BITS - DATA_BITS;
    localparam int RW = REMOTE_ADDR_WIDTH - DATA_BITS;
    localparam int NW = BUFFER_BURST_BITS + 3 - DATA_BITS;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic              arb_err_q, arb_err_d;
    logic [LW-1:0]     laddr_q, laddr_d;
    logic [RW-1:0]     raddr_q, raddr_d;
    logic [NW-1:0]     length_q, length_d;
    logic [MEM_TAG:0]  tag_q, tag_d;
    logic [1:0][CW-1:0] outst_q, outst_d;
    logic [1:0]        elig, inc, dec;
    logic              sel, cport;

    assign elig[0] = s0_tcq_valid & port_en[0] & (outst_q[0] < CW'(MAX_OUTSTANDING));
    assign elig[1] = s1_tcq_valid & port_en[1] & (outst_q[1] < CW'(MAX_OUTSTANDING));
    assign sel     = &elig ? rr_q : elig[1];

    // Completion path is purely combinational, steered by the upstream tag MSB
    assign cport         = m_tcq_ctag[MEM_TAG];
    assign s0_tcq_cvalid = m_tcq_cvalid & ~cport;
    assign s1_tcq_cvalid = m_tcq_cvalid & cport;
    assign s0_tcq_ctag   = m_tcq_ctag[MEM_TAG-1:0];
    assign s1_tcq_ctag   = m_tcq_ctag[MEM_TAG-1:0];
    assign m_tcq_cready  = cport ? s1_tcq_cready : s0_tcq_cready;

    assign inc[0] = (state_q == ISSUE) & m_tcq_ready & ~gnt_q;
    assign inc[1] = (state_q == ISSUE) & m_tcq_ready & gnt_q;
    assign dec[0] = s0_tcq_cvalid & s0_tcq_cready;
    assign dec[1] = s1_tcq_cvalid & s1_tcq_cready;

    assign m_tcq_valid  = valid_q;
    assign m_tcq_laddr  = laddr_q;
    assign m_tcq_raddr  = raddr_q;
    assign m_tcq_length = length_q;
    assign m_tcq_tag    = tag_q;
    assign arb_err      = arb_err_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        laddr_d      = laddr_q;
        raddr_d      = raddr_q;
        length_d     = length_q;
        tag_d        = tag_q;
        s0_tcq_ready = 1'b0;
        s1_tcq_ready = 1'b0;
        case (state_q)
            IDLE: if (|elig) begin
                gnt_d        = sel;
                laddr_d      = sel ? s1_tcq_laddr : s0_tcq_laddr;
                raddr_d      = sel ? s1_tcq_raddr : s0_tcq_raddr;
                length_d     = sel ? s1_tcq_length : s0_tcq_length;
                tag_d        = {sel, sel ? s1_tcq_tag : s0_tcq_tag};
                valid_d      = 1'b1;
                s0_tcq_ready = ~sel;
                s1_tcq_ready = sel;
                state_d      = ISSUE;
            end
            ISSUE: if (m_tcq_ready) begin
                valid_d = 1'b0;
                rr_d    = ~gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // An issue and a completion on the same port in one cycle cancel out
    always_comb begin
        arb_err_d = arb_err_q;
        for (int n = 0; n < 2; n++) begin
            outst_d[n] = outst_q[n];
            if (inc[n] & ~dec[n])
                outst_d[n] = outst_q[n] + CW'(1);
            else if (dec[n] & ~inc[n] & (outst_q[n] != '0))
                outst_d[n] = outst_q[n] - CW'(1);
            else if (dec[n] & ~inc[n])
                arb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            rr_q      <= 1'b0;
            gnt_q     <= 1'b0;
            arb_err_q <= 1'b0;
            outst_q   <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            arb_err_q <= arb_err_d;
            outst_q   <= outst_d;
        end
    end

    always_ff @(posedge clk) begin
        laddr_q  <= laddr_d;
        raddr_q  <= raddr_d;
        length_q <= length_d;
        tag_q    <= tag_d;
    end

`ifdef DMA_TCQ_ARB_STATS_EN
    logic [1:0][15:0] cnt_q, cnt_d;

    assign cnt_d[0] = cnt_q[0] + 16'(inc[0]);
    assign cnt_d[1] = cnt_q[1] + 16'(inc[1]);
    assign arb_stat = {cnt_q[1], cnt_q[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_dma_tcq_arb.sv
// tb_dma_tcq_arb: directed sequences, a completion-routing vector table and a randomized run against a reference model.
module tb_dma_tcq_arb;
    localparam int LW = 12, RW = 28, NW = 5, TW = 5, MAXO = 4;

    logic clk = 1'b0, rst;
    logic s0_tcq_valid, s0_tcq_ready, s0_tcq_cvalid, s0_tcq_cready;
    logic s1_tcq_valid, s1_tcq_ready, s1_tcq_cvalid, s1_tcq_cready;
    logic [LW-1:0] s0_tcq_laddr, s1_tcq_laddr, m_tcq_laddr;
    logic [RW-1:0] s0_tcq_raddr, s1_tcq_raddr, m_tcq_raddr;
    logic [NW-1:0] s0_tcq_length, s1_tcq_length, m_tcq_length;
    logic [TW-1:0] s0_tcq_tag, s1_tcq_tag, s0_tcq_ctag, s1_tcq_ctag;
    logic m_tcq_valid, m_tcq_ready, m_tcq_cvalid, m_tcq_cready, arb_err;
    logic [TW:0] m_tcq_tag, m_tcq_ctag;
    logic [1:0] port_en;
`ifdef DMA_TCQ_ARB_STATS_EN
    logic [31:0] arb_stat;
`endif

    dma_tcq_arb dut (
        .clk(clk), .rst(rst),
        .s0_tcq_valid(s0_tcq_valid), .s0_tcq_ready(s0_tcq_ready), .s0_tcq_laddr(s0_tcq_laddr),
        .s0_tcq_raddr(s0_tcq_raddr), .s0_tcq_length(s0_tcq_length), .s0_tcq_tag(s0_tcq_tag),
        .s0_tcq_cvalid(s0_tcq_cvalid), .s0_tcq_cready(s0_tcq_cready), .s0_tcq_ctag(s0_tcq_ctag),
        .s1_tcq_valid(s1_tcq_valid), .s1_tcq_ready(s1_tcq_ready), .s1_tcq_laddr(s1_tcq_laddr),
        .s1_tcq_raddr(s1_tcq_raddr), .s1_tcq_length(s1_tcq_length), .s1_tcq_tag(s1_tcq_tag),
        .s1_tcq_cvalid(s1_tcq_cvalid), .s1_tcq_cready(s1_tcq_cready), .s1_tcq_ctag(s1_tcq_ctag),
        .m_tcq_valid(m_tcq_valid), .m_tcq_ready(m_tcq_ready), .m_tcq_laddr(m_tcq_laddr),
        .m_tcq_raddr(m_tcq_raddr), .m_tcq_length(m_tcq_length), .m_tcq_tag(m_tcq_tag),
        .m_tcq_cvalid(m_tcq_cvalid), .m_tcq_cready(m_tcq_cready), .m_tcq_ctag(m_tcq_ctag),
        .port_en(port_en),
`ifdef DMA_TCQ_ARB_STATS_EN
        .arb_stat(arb_stat),
`endif
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic [TW:0] got[$];
    int got_cyc[$];

    typedef struct {
        logic cv; logic [TW:0] ct; logic cr0, cr1;
        logic e_cv0, e_cv1; logic [TW-1:0] e_ct; logic e_cr;
    } cvec_t;
    cvec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        {s0_tcq_valid, s0_tcq_cready, s0_tcq_laddr, s0_tcq_raddr, s0_tcq_length, s0_tcq_tag} = '0;
        {s1_tcq_valid, s1_tcq_cready, s1_tcq_laddr, s1_tcq_raddr, s1_tcq_length, s1_tcq_tag} = '0;
        {m_tcq_ready, m_tcq_cvalid, m_tcq_ctag} = '0;
        port_en = 2'b11;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts m_tcq handshakes over a fixed window with inputs held constant
    task automatic collect(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            #1;
            if (m_tcq_valid && m_tcq_ready) begin
                got.push_back(m_tcq_tag);
                got_cyc.push_back(c);
            end
            @(negedge clk);
        end
    endtask

    // Reference model state (transaction level)
    bit busy, rr, gp, err, g;
    int outst[2];
    int cnt[2];
    logic [LW-1:0] q_laddr;
    logic [RW-1:0] q_raddr;
    logic [NW-1:0] q_len;
    logic [TW:0] q_tag;

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_ready", {s0_tcq_ready, s1_tcq_ready}, 2'b00);
        chk("reset_mvalid", m_tcq_valid, 1'b0);
        chk("reset_err", arb_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{1'b1, 6'h05, 1'b1, 1'b0, 1'b1, 1'b0, 5'h05, 1'b1};
        tbl[1] = '{1'b1, 6'h05, 1'b0, 1'b1, 1'b1, 1'b0, 5'h05, 1'b0};
        tbl[2] = '{1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 5'h1F, 1'b1};
        tbl[3] = '{1'b1, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[4] = '{1'b0, 6'h2A, 1'b1, 1'b1, 1'b0, 1'b0, 5'h0A, 1'b1};
        tbl[5] = '{1'b0, 6'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'h11, 1'b0};
        for (int i = 0; i < 6; i++) begin
            m_tcq_cvalid = tbl[i].cv; m_tcq_ctag = tbl[i].ct;
            s0_tcq_cready = tbl[i].cr0; s1_tcq_cready = tbl[i].cr1;
            #1;
            chk("tbl_cpl", {s0_tcq_cvalid, s1_tcq_cvalid, s0_tcq_ctag, s1_tcq_ctag, m_tcq_cready},
                {tbl[i].e_cv0, tbl[i].e_cv1, tbl[i].e_ct, tbl[i].e_ct, tbl[i].e_cr});
            @(negedge clk);
        end

        // Port 0 alone, tags 1..3
        do_reset();
        m_tcq_ready = 1'b1; s0_tcq_valid = 1'b1; s0_tcq_tag = 5'd1;
        got.delete(); got_cyc.delete();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_tcq_valid) begin got.push_back(m_tcq_tag); got_cyc.push_back(c); end
            g = s0_tcq_ready;
            @(negedge clk);
            if (g) begin
                if (s0_tcq_tag == 5'd3) s0_tcq_valid = 1'b0;
                else s0_tcq_tag = s0_tcq_tag + 5'd1;
            end
        end
        chk("seq1_count", got.size(), 3);
        for (int i = 0; i < 3; i++) chk("seq1_tag", i < got.size() ? got[i] : 6'h3f, 6'(i + 1));
        chk("seq1_latency", got_cyc.size() > 0 ? got_cyc[0] : -1, 1);
        chk("seq1_gap", got_cyc.size() > 2 ? got_cyc[2] - got_cyc[1] : -1, 2);
        chk("seq1_gap0", got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1, 2);

        // Both ports continuously valid
        do_reset();
        m_tcq_ready = 1'b1;
        s0_tcq_valid = 1'b1; s0_tcq_tag = 5'h0A;
        s1_tcq_valid = 1'b1; s1_tcq_tag = 5'h0B;
        got.delete(); got_cyc.delete();
        collect(8);
        chk("rr_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rr_tag", i < got.size() ? got[i] : 6'h3f, (i % 2) ? 6'h2B : 6'h0A);

        // Credit limit then one completion frees a slot
        do_reset();
        m_tcq_ready = 1'b1; s0_tcq_valid = 1'b1; s0_tcq_tag = 5'h02;
        got.delete(); got_cyc.delete();
        collect(20);
        chk("limit_count", got.size(), MAXO);
        #1;
        chk("limit_ready", s0_tcq_ready, 1'b0);
        @(negedge clk);
        m_tcq_cvalid = 1'b1; m_tcq_ctag = 6'h02; s0_tcq_cready = 1'b1;
        @(negedge clk);
        m_tcq_cvalid = 1'b0; s0_tcq_cready = 1'b0;
        collect(6);
        chk("limit_fifth", got.size(), MAXO + 1);

        // Completion stalled by port 1
        do_reset();
        m_tcq_cvalid = 1'b1; m_tcq_ctag = 6'h25;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("cpl_stall", {s0_tcq_cvalid, s1_tcq_cvalid, s1_tcq_ctag, m_tcq_cready}, {1'b0, 1'b1, 5'd5, 1'b0});
            @(negedge clk);
        end
        s1_tcq_cready = 1'b1;
        #1;
        chk("cpl_release", m_tcq_cready, 1'b1);
        @(negedge clk);
        m_tcq_cvalid = 1'b0;
        #1;
        chk("cpl_err_p1", arb_err, 1'b1);
        @(negedge clk);

        // Underflow completion: sticky error, counter must not wrap
        do_reset();
        m_tcq_cvalid = 1'b1; m_tcq_ctag = 6'h01; s0_tcq_cready = 1'b1;
        @(negedge clk);
        m_tcq_cvalid = 1'b0; s0_tcq_cready = 1'b0;
        #1;
        chk("uflow_err", arb_err, 1'b1);
        @(negedge clk);
        m_tcq_ready = 1'b1; s0_tcq_valid = 1'b1;
        got.delete(); got_cyc.delete();
        collect(20);
        chk("uflow_nowrap", got.size(), MAXO);
        chk("uflow_sticky", arb_err, 1'b1);
        rst = 1'b1;
        #1;
        chk("uflow_async_clr", arb_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset while a request is pending
        do_reset();
        m_tcq_ready = 1'b1; s0_tcq_valid = 1'b1;
        got.delete(); got_cyc.delete();
        collect(4);
        chk("areset_pre", got.size(), 2);
        m_tcq_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("areset_issue", m_tcq_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("areset_drop", m_tcq_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; m_tcq_ready = 1'b1;
        got.delete(); got_cyc.delete();
        collect(20);
        chk("areset_credits", got.size(), MAXO);

        // Randomized run against the reference model
        do_reset();
        busy = 0; rr = 0; gp = 0; err = 0;
        outst = '{0, 0}; cnt = '{0, 0};
        for (int c = 0; c < 3000; c++) begin
            bit e0, e1, np, cp, hs;
            bit [1:0] inc, dec;
            s0_tcq_valid = $urandom_range(0, 3) != 0; s1_tcq_valid = $urandom_range(0, 3) != 0;
            s0_tcq_laddr = LW'($urandom); s1_tcq_laddr = LW'($urandom);
            s0_tcq_raddr = RW'($urandom); s1_tcq_raddr = RW'($urandom);
            s0_tcq_length = NW'($urandom); s1_tcq_length = NW'($urandom);
            s0_tcq_tag = TW'($urandom); s1_tcq_tag = TW'($urandom);
            port_en = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            m_tcq_ready = $urandom_range(0, 3) != 0;
            m_tcq_cvalid = $urandom_range(0, 3) == 0;
            m_tcq_ctag = 6'($urandom);
            s0_tcq_cready = 1'($urandom); s1_tcq_cready = 1'($urandom);
            #1;
            e0 = s0_tcq_valid && port_en[0] && outst[0] < MAXO;
            e1 = s1_tcq_valid && port_en[1] && outst[1] < MAXO;
            np = (e0 && e1) ? rr : e1;
            chk("rnd_ready", {s0_tcq_ready, s1_tcq_ready},
                {!busy && (e0 || e1) && !np, !busy && (e0 || e1) && np});
            chk("rnd_mvalid", m_tcq_valid, busy);
            if (busy)
                chk("rnd_payload", {m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag},
                    {q_laddr, q_raddr, q_len, q_tag});
            cp = m_tcq_ctag[TW];
            chk("rnd_cpl", {s0_tcq_cvalid, s1_tcq_cvalid, s0_tcq_ctag, s1_tcq_ctag, m_tcq_cready},
                {m_tcq_cvalid && !cp, m_tcq_cvalid && cp, m_tcq_ctag[TW-1:0], m_tcq_ctag[TW-1:0],
                 cp ? s1_tcq_cready : s0_tcq_cready});
            chk("rnd_err", arb_err, err);
`ifdef DMA_TCQ_ARB_STATS_EN
            chk("rnd_stat", arb_stat, {16'(cnt[1]), 16'(cnt[0])});
`endif
            hs = busy && m_tcq_ready;
            inc = {hs && gp, hs && !gp};
            dec = {m_tcq_cvalid && cp && s1_tcq_cready, m_tcq_cvalid && !cp && s0_tcq_cready};
            for (int n = 0; n < 2; n++) begin
                if (inc[n]) cnt[n] = (cnt[n] + 1) % 65536;
                if (inc[n] && !dec[n]) outst[n]++;
                else if (dec[n] && !inc[n]) begin
                    if (outst[n] == 0) err = 1;
                    else outst[n]--;
                end
            end
            if (hs) begin
                busy = 0; rr = !gp;
            end else if (!busy && (e0 || e1)) begin
                busy = 1; gp = np;
                q_laddr = np ? s1_tcq_laddr : s0_tcq_laddr;
                q_raddr = np ? s1_tcq_raddr : s0_tcq_raddr;
                q_len = np ? s1_tcq_length : s0_tcq_length;
                q_tag = {np, np ? s1_tcq_tag : s0_tcq_tag};
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
